picosoc_a2disk_mv: RTL

Memory-mapped PicoSoC peripheral that bridges firmware to `NUM_VOLUMES` block-device volumes of the A2FPGA disk subsystem. Each volume gets a per-volume request FSM: captured read/write requests with latched LBA and block count, a self-clearing ack handshake and abort detection. A global bank provides a maskable interrupt on new requests. It sits on the PicoSoC `iomem` bus beside the other SoC peripherals.

---
 rtl/picosoc_a2disk_mv_if.sv | 17 +
 rtl/picosoc_a2disk_mv.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/picosoc_a2disk_mv_if.sv
// drive_volume_if: one A2FPGA block-device volume channel between the disk subsystem and the SoC bridge
interface drive_volume_if;
  logic        ready;
  logic        mounted;
  logic        readonly;
  logic [31:0] size;
  logic        ack;
  logic        active;
  logic [31:0] lba;
  logic [5:0]  blk_cnt;
  logic        rd;
  logic        wr;
  modport volume (
    output ready, mounted, readonly, size, ack,
    input  active, lba, blk_cnt, rd, wr
  );
endinterface

// File: rtl/picosoc_a2disk_mv.sv
// picosoc_a2disk_mv: iomem bridge exposing NUM_VOLUMES block-device request channels with a maskable request interrupt
module picosoc_a2disk_mv #(
  parameter int NUM_VOLUMES = 2
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           iomem_valid,
  input  logic [3:0]     iomem_wstrb,
  input  logic [31:0]    iomem_addr,
  input  logic [31:0]    iomem_wdata,
  output logic [31:0]    iomem_rdata,
  output logic           iomem_ready,
  output logic           irq,
  drive_volume_if.volume volumes [NUM_VOLUMES]
);
  localparam int N = NUM_VOLUMES;
  typedef enum logic [1:0] {IDLE, PENDING, ACKED} st_t;
  st_t         st [N];
  logic [N-1:0] rdy_q, mnt_q, ro_q, ack_q, dir_q, err_q, abt_q, req_q, irq_pend, irq_en;
  logic [N-1:0] act, rd, wr, req, we, unmount, ack_wr, pend_set, pend_clr;
  logic [31:0]  size_q [N];
  logic [31:0]  lba_q [N];
  logic [31:0]  lba_v [N];
  logic [5:0]   cnt_q [N];
  logic [5:0]   cnt_v [N];
  logic [31:0]  vol_rd, rd_val;
  logic         acc, wr_acc, glb, addr_unused;
  logic [2:0]   vsel;
  logic [3:0]   rsel;
  for (genvar v = 0; v < N; v++) begin : g_vol
    assign act[v]            = volumes[v].active;
    assign rd[v]             = volumes[v].rd;
    assign wr[v]             = volumes[v].wr;
    assign lba_v[v]          = volumes[v].lba;
    assign cnt_v[v]          = volumes[v].blk_cnt;
    assign volumes[v].ready    = rdy_q[v];
    assign volumes[v].mounted  = mnt_q[v];
    assign volumes[v].readonly = ro_q[v];
    assign volumes[v].size     = size_q[v];
    assign volumes[v].ack      = ack_q[v];
  end
  assign acc         = iomem_valid && !iomem_ready;
  assign wr_acc      = acc && |iomem_wstrb;
  assign vsel        = iomem_addr[9:7];
  assign glb         = iomem_addr[6];
  assign rsel        = iomem_addr[5:2];
  assign req         = rd | wr;
  assign addr_unused = ^{iomem_addr[31:10], iomem_addr[1:0]};
  assign pend_clr    = (wr_acc && glb && rsel == 4'd0) ? iomem_wdata[N-1:0] : '0;
  always_comb begin
    we       = '0;
    unmount  = '0;
    ack_wr   = '0;
    pend_set = '0;
    vol_rd   = '0;
    for (int k = 0; k < N; k++) begin
      we[k]       = wr_acc && !glb && vsel == 3'(k);
      unmount[k]  = we[k] && iomem_wstrb[0] && rsel == 4'd2 && !iomem_wdata[0];
      ack_wr[k]   = we[k] && iomem_wstrb[0] && rsel == 4'd9 && iomem_wdata[0];
      pend_set[k] = st[k] == IDLE && req[k] && !req_q[k] && !unmount[k];
      if (vsel == 3'(k))
        case (rsel)
          4'd0:    vol_rd = {31'd0, rdy_q[k]};
          4'd1:    vol_rd = {31'd0, act[k]};
          4'd2:    vol_rd = {31'd0, mnt_q[k]};
          4'd3:    vol_rd = {31'd0, ro_q[k]};
          4'd4:    vol_rd = size_q[k];
          4'd5:    vol_rd = lba_q[k];
          4'd6:    vol_rd = {26'd0, cnt_q[k]};
          4'd7:    vol_rd = {31'd0, rd[k]};
          4'd8:    vol_rd = {31'd0, wr[k]};
          4'd9:    vol_rd = {31'd0, ack_q[k]};
          4'd10:   vol_rd = {27'd0, abt_q[k], err_q[k], dir_q[k], st[k]};
          default: vol_rd = '0;
        endcase
    end
    rd_val = !glb ? vol_rd :
             rsel == 4'd0 ? 32'(irq_pend) :
             rsel == 4'd1 ? 32'(irq_en) :
             rsel == 4'd2 ? 32'(N) : '0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      irq         <= 1'b0;
      irq_pend    <= '0;
      irq_en      <= '0;
      rdy_q       <= '0;
      mnt_q       <= '0;
      ro_q        <= '0;
      ack_q       <= '0;
      dir_q       <= '0;
      err_q       <= '0;
      abt_q       <= '0;
      req_q       <= '0;
      for (int k = 0; k < N; k++) begin
        st[k]     <= IDLE;
        size_q[k] <= '0;
        lba_q[k]  <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      iomem_ready <= acc;
      iomem_rdata <= (acc && !(|iomem_wstrb)) ? rd_val : '0;
      irq         <= |(irq_pend & irq_en);
      irq_pend    <= (irq_pend & ~pend_clr) | pend_set;
      req_q       <= req;
      if (wr_acc && glb && rsel == 4'd1) irq_en <= iomem_wdata[N-1:0];
      for (int k = 0; k < N; k++) begin
        if (we[k] && iomem_wstrb[0] && rsel == 4'd0) rdy_q[k] <= iomem_wdata[0];
        if (we[k] && iomem_wstrb[0] && rsel == 4'd2) mnt_q[k] <= iomem_wdata[0];
        if (we[k] && iomem_wstrb[0] && rsel == 4'd3) ro_q[k] <= iomem_wdata[0];
        for (int b = 0; b < 4; b++)
          if (we[k] && rsel == 4'd4 && iomem_wstrb[b]) size_q[k][8*b +: 8] <= iomem_wdata[8*b +: 8];
        // unmount forces the channel idle from any state; latched request info stays readable
        if (unmount[k]) begin
          st[k]    <= IDLE;
          ack_q[k] <= 1'b0;
        end else
          case (st[k])
            IDLE:
              if (pend_set[k]) begin
                st[k]    <= PENDING;
                lba_q[k] <= lba_v[k];
                cnt_q[k] <= cnt_v[k];
                dir_q[k] <= wr[k] && !rd[k];
                err_q[k] <= rd[k] && wr[k];
                abt_q[k] <= 1'b0;
              end
            PENDING:
              if (!req[k]) begin
                st[k]    <= IDLE;
                abt_q[k] <= 1'b1;
              end else if (ack_wr[k]) begin
                st[k]    <= ACKED;
                ack_q[k] <= 1'b1;
              end
            default:
              if (!req[k]) begin
                st[k]    <= IDLE;
                ack_q[k] <= 1'b0;
              end
          endcase
      end
    end
  end
endmodule
